// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the in-place FFT sequencer
// Contents: FSM state enum, bitrev() helper, fft_delay() read-to-write latency.
// Optional feature macro: FFT_SEQ_BITREV_EN (adds BITREV / BREV_DRAIN states).
package fft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_DRAIN      = 3'd2,
`ifdef FFT_SEQ_BITREV_EN
        ST_BITREV     = 3'd3,
        ST_BREV_DRAIN = 3'd4,
`endif
        ST_DONE       = 3'd5
    } fft_state_e;

    // Cycles from a read issue to the matching write-back (D).
    function automatic int fft_delay(input int ram_lat, input int pe_lat);
        return ram_lat + pe_lat;
    endfunction

    // Reverses the low 'width' bits of value; 12 bits covers POINTS up to 4096.
    function automatic logic [11:0] bitrev(input logic [11:0] value, input int width);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            if (i < width) begin
                r[width - 1 - i] = value[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_inplace_sequencer_if.sv
// rtl/fft_inplace_sequencer_if.sv - sample-memory / PE bus of the FFT sequencer
// master: sequencer side (drives read, twiddle, PE control and write strobes,
//         receives pe_ovf_i).
// slave:  memory / processing-element side.
interface fft_inplace_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_a_o;
    logic [ADDR_W-1:0] rd_addr_b_o;
    logic [ADDR_W-2:0] tw_addr_o;
    logic              tw_conj_o;
    logic              pe_shift_o;
    logic              pe_bypass_o;
    logic              pe_ovf_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_a_o;
    logic [ADDR_W-1:0] wr_addr_b_o;

    modport master (
        output rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, tw_conj_o,
        output pe_shift_o, pe_bypass_o,
        input  pe_ovf_i,
        output wr_en_o, wr_addr_a_o, wr_addr_b_o
    );

    modport slave (
        input  rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, tw_conj_o,
        input  pe_shift_o, pe_bypass_o,
        output pe_ovf_i,
        input  wr_en_o, wr_addr_a_o, wr_addr_b_o
    );
endinterface

// File: rtl/fft_addr_pipe.sv
// rtl/fft_addr_pipe.sv - DEPTH-cycle delay line for {en, addr_a, addr_b}
// Ports: clk_i, rst_i (sync, active-high), clr_i (sync flush),
//        en_i/addr_a_i/addr_b_i (push side), en_o/addr_a_o/addr_b_o (delayed).
module fft_addr_pipe #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    output logic              en_o,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [ADDR_W-1:0] addr_b_o
);
    localparam int W = 1 + 2 * ADDR_W;

    logic [W-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {en_i, addr_a_i, addr_b_i};
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {en_o, addr_a_o, addr_b_o} = pipe_q[DEPTH-1];
endmodule

// File: rtl/fft_inplace_sequencer.sv
// rtl/fft_inplace_sequencer.sv - radix-2 in-place FFT address/control sequencer
// Ports: clk_i, rst_i (sync, active-high); run_i/inverse_i/abort_i control;
//        busy_o, done_o, stage_o, total_shifts_o status;
//        mem (fft_inplace_sequencer_if.master) read/twiddle/PE/write bus.
// Optional feature macro: FFT_SEQ_BITREV_EN (bit-reverse reorder pass at end).
module fft_inplace_sequencer
    import fft_pkg::*;
#(
    parameter int POINTS    = 1024,
    parameter int MAXSHIFTS = 8,
    parameter int RAM_LAT   = 1,
    parameter int PE_LAT    = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       run_i,
    input  logic                       inverse_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(POINTS)-1:0]  stage_o,
    output logic [MAXSHIFTS-1:0]       total_shifts_o,
    fft_inplace_sequencer_if.master    mem
);
    localparam int ADDR_W = $clog2(POINTS);
    localparam int D      = fft_delay(RAM_LAT, PE_LAT);
    localparam int DC_W   = (D > 1) ? $clog2(D) : 1;

    localparam logic [ADDR_W-1:0] HALF_V     = ADDR_W'(POINTS / 2);
    localparam logic [ADDR_W-1:0] LAST_K     = ADDR_W'(POINTS / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_STAGE = ADDR_W'(ADDR_W - 1);
    localparam logic [DC_W-1:0]   D_LAST     = DC_W'(D - 1);

    fft_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]    stage_q, stage_d;
    logic [DC_W-1:0]      dcnt_q, dcnt_d;
    logic                 inv_q, inv_d;
    logic                 shift_q, shift_d;
    logic                 ovf_q, ovf_d;
    logic [MAXSHIFTS-1:0] tshift_q, tshift_d;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_a, rd_b, push_a, push_b;
    logic [ADDR_W-2:0] tw;
    logic              bypass;
    logic              ovf_hit;
    logic              pipe_clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_a, wr_b;

    // Butterfly addressing: a is k with a 0 inserted at bit log2(h), b sets that bit.
    logic [ADDR_W-1:0] h, low_mask, bf_a, bf_b;
    logic [ADDR_W-2:0] tw_v;

    always_comb begin
        h        = HALF_V >> stage_q;
        low_mask = h - 1'b1;
        bf_a     = ((cnt_q & ~low_mask) << 1) | (cnt_q & low_mask);
        bf_b     = bf_a | h;
        tw_v     = (cnt_q[ADDR_W-2:0] & low_mask[ADDR_W-2:0]) << stage_q;
    end

`ifdef FFT_SEQ_BITREV_EN
    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(POINTS - 1);
    logic [ADDR_W-1:0] rev_i;
    assign rev_i = ADDR_W'(bitrev(12'(cnt_q), ADDR_W));
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        dcnt_d   = dcnt_q;
        inv_d    = inv_q;
        shift_d  = shift_q;
        ovf_d    = ovf_q;
        tshift_d = tshift_q;
        rd_en    = 1'b0;
        rd_a     = '0;
        rd_b     = '0;
        push_a   = '0;
        push_b   = '0;
        tw       = '0;
        bypass   = 1'b0;
        ovf_hit  = ovf_q | (wr_en & mem.pe_ovf_i);

        case (state_q)
            ST_IDLE: begin
                if (run_i && !abort_i) begin
                    state_d  = ST_ISSUE;
                    inv_d    = inverse_i;
                    tshift_d = '0;
                    stage_d  = '0;
                    cnt_d    = '0;
                    dcnt_d   = '0;
                    shift_d  = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            ST_ISSUE: begin
                rd_en  = 1'b1;
                rd_a   = bf_a;
                rd_b   = bf_b;
                push_a = bf_a;
                push_b = bf_b;
                tw     = tw_v;
                ovf_d  = ovf_hit;
                if (cnt_q == LAST_K) begin
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                ovf_d = ovf_hit;
                if (dcnt_q == D_LAST) begin
                    // Every write of this stage has landed: decide next stage's scaling.
                    dcnt_d = '0;
                    ovf_d  = 1'b0;
                    cnt_d  = '0;
                    if (stage_q == LAST_STAGE) begin
`ifdef FFT_SEQ_BITREV_EN
                        state_d = ST_BITREV;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + 1'b1;
                        shift_d = ovf_hit;
                        if (ovf_hit && (tshift_q != '1)) begin
                            tshift_d = tshift_q + 1'b1;
                        end
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
`ifdef FFT_SEQ_BITREV_EN
            ST_BITREV: begin
                // Each pair is swapped once, from its smaller index.
                if (cnt_q < rev_i) begin
                    rd_en  = 1'b1;
                    rd_a   = cnt_q;
                    rd_b   = rev_i;
                    push_a = rev_i;
                    push_b = cnt_q;
                    bypass = 1'b1;
                end
                if (cnt_q == LAST_I) begin
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    state_d = ST_BREV_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREV_DRAIN: begin
                if (dcnt_q == D_LAST) begin
                    dcnt_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_i && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            tshift_d = tshift_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            stage_q  <= '0;
            dcnt_q   <= '0;
            inv_q    <= 1'b0;
            shift_q  <= 1'b0;
            ovf_q    <= 1'b0;
            tshift_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            dcnt_q   <= dcnt_d;
            inv_q    <= inv_d;
            shift_q  <= shift_d;
            ovf_q    <= ovf_d;
            tshift_q <= tshift_d;
        end
    end

    assign pipe_clr = abort_i && (state_q != ST_IDLE);

    fft_addr_pipe #(
        .ADDR_W (ADDR_W),
        .DEPTH  (D)
    ) u_addr_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (pipe_clr),
        .en_i     (rd_en),
        .addr_a_i (push_a),
        .addr_b_i (push_b),
        .en_o     (wr_en),
        .addr_a_o (wr_a),
        .addr_b_o (wr_b)
    );

    assign busy_o         = (state_q != ST_IDLE);
    // An abort arriving in the DONE cycle suppresses the pulse.
    assign done_o         = (state_q == ST_DONE) && !abort_i;
    assign stage_o        = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) ? stage_q : '0;
    assign total_shifts_o = tshift_q;

    assign mem.rd_en_o     = rd_en;
    assign mem.rd_addr_a_o = rd_a;
    assign mem.rd_addr_b_o = rd_b;
    assign mem.tw_addr_o   = tw;
    assign mem.tw_conj_o   = inv_q && busy_o;
    assign mem.pe_shift_o  = shift_q && (state_q == ST_ISSUE);
`ifdef FFT_SEQ_BITREV_EN
    assign mem.pe_bypass_o = bypass;
`else
    assign mem.pe_bypass_o = 1'b0;
`endif
    assign mem.wr_en_o     = wr_en;
    assign mem.wr_addr_a_o = wr_a;
    assign mem.wr_addr_b_o = wr_b;
endmodule

// File: tb/tb_fft_inplace_sequencer.sv
// tb/tb_fft_inplace_sequencer.sv - directed self-checking bench for fft_inplace_sequencer
module tb_fft_inplace_sequencer;
    localparam int POINTS    = 8;
    localparam int MAXSHIFTS = 1;
    localparam int AW        = 3;
`ifdef FFT_SEQ_BITREV_EN
    localparam int DONE_CYC = 37;
`else
    localparam int DONE_CYC = 25;
`endif
    localparam int EXP_A  [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    localparam int EXP_B  [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    localparam int EXP_TW [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

    logic clk = 1'b0;
    logic rst, run, inverse, abort;
    logic busy, done;
    logic [AW-1:0] stage;
    logic [MAXSHIFTS-1:0] total;
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    fft_inplace_sequencer_if #(.ADDR_W(AW)) mem ();

    fft_inplace_sequencer #(
        .POINTS(POINTS), .MAXSHIFTS(MAXSHIFTS), .RAM_LAT(1), .PE_LAT(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .inverse_i(inverse), .abort_i(abort),
        .busy_o(busy), .done_o(done), .stage_o(stage), .total_shifts_o(total),
        .mem(mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected read activity in cycle c of a run whose run_i was taken in cycle 0.
    function automatic void exp_rd(input int c, output logic en, output int a, output int b,
                                   output int tw, output logic byp);
        en = 1'b0; a = 0; b = 0; tw = 0; byp = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (c >= 1 + 8 * s && c <= 4 + 8 * s) begin
                en = 1'b1;
                a  = EXP_A[4 * s + c - 1 - 8 * s];
                b  = EXP_B[4 * s + c - 1 - 8 * s];
                tw = EXP_TW[4 * s + c - 1 - 8 * s];
            end
        end
`ifdef FFT_SEQ_BITREV_EN
        if (c == 26) begin en = 1'b1; a = 1; b = 4; byp = 1'b1; end
        if (c == 28) begin en = 1'b1; a = 3; b = 6; byp = 1'b1; end
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".stage"}, stage, 0);
        chk({tag, ".total"}, total, 0);
        chk({tag, ".rd_en"}, mem.rd_en_o, 0);
        chk({tag, ".rd_a"}, mem.rd_addr_a_o, 0);
        chk({tag, ".rd_b"}, mem.rd_addr_b_o, 0);
        chk({tag, ".tw"}, mem.tw_addr_o, 0);
        chk({tag, ".tw_conj"}, mem.tw_conj_o, 0);
        chk({tag, ".pe_shift"}, mem.pe_shift_o, 0);
        chk({tag, ".pe_bypass"}, mem.pe_bypass_o, 0);
        chk({tag, ".wr_en"}, mem.wr_en_o, 0);
        chk({tag, ".wr_a"}, mem.wr_addr_a_o, 0);
        chk({tag, ".wr_b"}, mem.wr_addr_b_o, 0);
    endtask

    // Full run; ovf bit c drives pe_ovf_i during cycle c. A stray run_i at cycle 10 must be ignored.
    task automatic run_full(input logic inv, input logic [63:0] ovf);
        logic en, byp, wen, wbyp, sh1, sh2;
        int a, b, tw, wa, wb, wtw, stg, exp_tot;
        sh1 = |ovf[8:5];
        sh2 = |ovf[16:13];
        exp_tot = int'(sh1) + int'(sh2);
        if (exp_tot > 2 ** MAXSHIFTS - 1) exp_tot = 2 ** MAXSHIFTS - 1;
        cyc = 0;
        run = 1'b1;
        inverse = inv;
        for (int c = 1; c <= DONE_CYC + 1; c++) begin
            step();
            run = (c == 10);
            inverse = 1'b0;
            mem.pe_ovf_i = ovf[c];
            exp_rd(c, en, a, b, tw, byp);
            exp_rd(c - 4, wen, wa, wb, wtw, wbyp);
            stg = (c <= 8) ? 0 : (c <= 16) ? 1 : (c <= 24) ? 2 : 0;
            chk("rd_en", mem.rd_en_o, en);
            if (en) begin
                chk("rd_a", mem.rd_addr_a_o, a);
                chk("rd_b", mem.rd_addr_b_o, b);
                if (!byp) chk("tw", mem.tw_addr_o, tw);
            end
            chk("pe_bypass", mem.pe_bypass_o, byp);
            chk("wr_en", mem.wr_en_o, wen);
            if (wen) begin
                chk("wr_a", mem.wr_addr_a_o, wbyp ? wb : wa);
                chk("wr_b", mem.wr_addr_b_o, wbyp ? wa : wb);
            end
            chk("stage", stage, stg);
            chk("pe_shift", mem.pe_shift_o, en && ((stg == 1 && sh1) || (stg == 2 && sh2)));
            chk("busy", busy, c <= DONE_CYC);
            chk("done", done, c == DONE_CYC);
            chk("tw_conj", mem.tw_conj_o, inv && (c <= DONE_CYC));
            if (c == DONE_CYC) chk("total_at_done", total, exp_tot);
        end
        mem.pe_ovf_i = 1'b0;
    endtask

    // Run with abort in cycle abort_c; run_i pulsed at cycle 2 while busy.
    task automatic abort_run(input int ovf_c, input int abort_c, input int exp_tot);
        cyc = 0;
        run = 1'b1;
        inverse = 1'b1;
        for (int c = 1; c <= abort_c + 30; c++) begin
            step();
            run = (c == 2);
            inverse = 1'b0;
            mem.pe_ovf_i = (c == ovf_c);
            abort = (c == abort_c);
            if (c == abort_c + 1) begin
                chk("abort.rd_en", mem.rd_en_o, 0);
                chk("abort.total_hold", total, exp_tot);
            end
            if (c > abort_c) begin
                chk("abort.busy", busy, 0);
                chk("abort.wr_en", mem.wr_en_o, 0);
                chk("abort.done", done, 0);
            end
        end
        abort = 1'b0;
        mem.pe_ovf_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; inverse = 1'b0; abort = 1'b0; mem.pe_ovf_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check_all_zero("reset");

        // One stage-0 overflow: stage 1 scaled, one shift counted.
        run_full(1'b1, 64'b1 << 6);
        // Overflow in every stage: stages 1 and 2 scaled, counter saturates, last stage adds nothing.
        run_full(1'b0, (64'b1 << 6) | (64'b1 << 14) | (64'b1 << 22));

        // Abort in stage-0 drain, then abort during stage-1 issue with a shift already counted.
        abort_run(0, 6, 0);
        abort_run(6, 11, 1);

        // run_i and abort_i together in IDLE: abort wins.
        run = 1'b1; abort = 1'b1;
        step();
        run = 1'b0; abort = 1'b0;
        chk("run_abort.busy", busy, 0);
        chk("run_abort.rd_en", mem.rd_en_o, 0);
        step();
        chk("run_abort.busy2", busy, 0);

        // Reset during stage 1 with a concurrent run_i.
        cyc = 0;
        run = 1'b1; inverse = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            run = 1'b0; inverse = 1'b0;
            mem.pe_ovf_i = (c == 6);
        end
        mem.pe_ovf_i = 1'b0;
        chk("pre_reset.total", total, 1);
        chk("pre_reset.stage", stage, 1);
        rst = 1'b1; run = 1'b1;
        step();
        rst = 1'b0; run = 1'b0;
        check_all_zero("mid_reset");
        for (int c = 0; c < 8; c++) begin
            step();
            chk("post_reset.wr_en", mem.wr_en_o, 0);
            chk("post_reset.busy", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
